// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer: default timing constants,
// the counter-width helper and the per-bit filter state encoding.
package debounce_pkg;

  localparam int DEF_DEBOUNCE_CYCLES  = 742500;    // 10 ms at 74.25 MHz
  localparam int DEF_LONGPRESS_CYCLES = 74250000;  // 1 s at 74.25 MHz

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } filt_state_e;

  // Width of a counter that must hold values 0 .. cycles-1.
  function automatic int calc_cnt_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Board-input / conditioned-output bundle for input_debouncer.
// o_btn_long exists only when LONGPRESS_EN is defined.
interface input_debouncer_if #(
  parameter int N_BTN = 5,
  parameter int N_SW  = 8
);
  logic [N_BTN-1:0] i_push_btn;
  logic [N_SW-1:0]  i_DIP_sw;
  logic [N_BTN-1:0] o_btn_level;
  logic [N_BTN-1:0] o_btn_press;
  logic [N_BTN-1:0] o_btn_release;
  logic [N_SW-1:0]  o_sw_level;
  logic             o_sw_change;
`ifdef LONGPRESS_EN
  logic [N_BTN-1:0] o_btn_long;

  modport master (
    output i_push_btn, i_DIP_sw,
    input  o_btn_level, o_btn_press, o_btn_release, o_sw_level, o_sw_change, o_btn_long
  );
  modport slave (
    input  i_push_btn, i_DIP_sw,
    output o_btn_level, o_btn_press, o_btn_release, o_sw_level, o_sw_change, o_btn_long
  );
`else
  modport master (
    output i_push_btn, i_DIP_sw,
    input  o_btn_level, o_btn_press, o_btn_release, o_sw_level, o_sw_change
  );
  modport slave (
    input  i_push_btn, i_DIP_sw,
    output o_btn_level, o_btn_press, o_btn_release, o_sw_level, o_sw_change
  );
`endif
endinterface

// File: rtl/debounce_cell.sv
// One-bit synchroniser plus bounce filter. A new input value is accepted
// after it has been seen unchanged for DEBOUNCE_CYCLES consecutive cycles.
module debounce_cell
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_din,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int               CNT_W    = calc_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync;
  filt_state_e            w_state;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign w_state = (w_sync == r_level) ? ST_STABLE : ST_COUNTING;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values,
      // which is what makes the shift below a real multi-stage synchroniser.
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (w_state)
        ST_STABLE: r_cnt <= '0;
        ST_COUNTING: begin
          if (r_cnt == CNT_LAST) begin
            r_level <= w_sync;
            r_cnt   <= '0;
            r_rise  <= w_sync;
            r_fall  <= ~w_sync;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/input_debouncer.sv
// Conditions raw push buttons and DIP switches: per-bit debounce cells,
// switch-change aggregation and, with LONGPRESS_EN, per-button long-press pulses.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int N_BTN            = 5,
  parameter int N_SW             = 8,
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int LONGPRESS_CYCLES = DEF_LONGPRESS_CYCLES
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input_debouncer_if.slave   bus
);

  logic [N_BTN-1:0] w_btn_level;
  logic [N_BTN-1:0] w_btn_rise;
  logic [N_BTN-1:0] w_btn_fall;
  logic [N_SW-1:0]  w_sw_level;
  logic [N_SW-1:0]  w_sw_rise;
  logic [N_SW-1:0]  w_sw_fall;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    debounce_cell #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_din     (bus.i_push_btn[g]),
      .o_level   (w_btn_level[g]),
      .o_rise    (w_btn_rise[g]),
      .o_fall    (w_btn_fall[g])
    );
  end

  for (genvar g = 0; g < N_SW; g++) begin : g_sw
    debounce_cell #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_din     (bus.i_DIP_sw[g]),
      .o_level   (w_sw_level[g]),
      .o_rise    (w_sw_rise[g]),
      .o_fall    (w_sw_fall[g])
    );
  end

  assign bus.o_btn_level   = w_btn_level;
  assign bus.o_btn_press   = w_btn_rise;
  assign bus.o_btn_release = w_btn_fall;
  assign bus.o_sw_level    = w_sw_level;
  // OR of flop outputs only, so the change pulse stays aligned with the level update.
  assign bus.o_sw_change   = |(w_sw_rise | w_sw_fall);

`ifdef LONGPRESS_EN
  localparam int              LP_W   = calc_cnt_w(LONGPRESS_CYCLES + 1);
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONGPRESS_CYCLES);
  localparam logic [LP_W-1:0] LP_PRE = LP_W'(LONGPRESS_CYCLES - 1);

  logic [LP_W-1:0]  r_long_cnt [N_BTN];
  logic [N_BTN-1:0] r_btn_long;

  // Counter saturates at LP_MAX, so each hold yields a single pulse.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < N_BTN; i++) r_long_cnt[i] <= '0;
      r_btn_long <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        r_btn_long[i] <= 1'b0;
        if (!w_btn_level[i]) begin
          r_long_cnt[i] <= '0;
        end else if (r_long_cnt[i] != LP_MAX) begin
          r_long_cnt[i] <= r_long_cnt[i] + LP_W'(1);
          r_btn_long[i] <= (r_long_cnt[i] == LP_PRE);
        end
      end
    end
  end

  assign bus.o_btn_long = r_btn_long;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with DEBOUNCE_CYCLES=16, SYNC_STAGES=2,
// LONGPRESS_CYCLES=64; a clean edge driven just after edge 0 shows up after edge 18.
module tb_input_debouncer;

  localparam int N_BTN = 5;
  localparam int N_SW  = 8;
  localparam int LAT   = 18;
  localparam int LP    = 64;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  input_debouncer_if #(.N_BTN(N_BTN), .N_SW(N_SW)) bus ();

  input_debouncer #(
    .N_BTN            (N_BTN),
    .N_SW             (N_SW),
    .SYNC_STAGES      (2),
    .DEBOUNCE_CYCLES  (16),
    .LONGPRESS_CYCLES (LP)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [N_BTN-1:0] btn, input logic [N_SW-1:0] sw);
    bus.i_push_btn = btn;
    bus.i_DIP_sw   = sw;
    step(LAT + 8);
  endtask

  task automatic test_reset;
    rst_n          = 1'b0;
    bus.i_push_btn = '1;
    bus.i_DIP_sw   = '1;
    step(3);
    n_cmp++;
    if ({bus.o_btn_level, bus.o_btn_press, bus.o_btn_release, bus.o_sw_level, bus.o_sw_change} !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs got lvl=%h prs=%h rel=%h sw=%h chg=%b expected all 0",
               bus.o_btn_level, bus.o_btn_press, bus.o_btn_release, bus.o_sw_level, bus.o_sw_change);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= LAT + 4; k++) begin
      step(1);
      n_cmp++;
      if (bus.o_sw_level !== ((k >= LAT) ? 8'hFF : 8'h00)) begin
        n_mis++;
        $display("FAIL post_reset_sw_level k=%0d got=%h", k, bus.o_sw_level);
      end
      n_cmp++;
      if (bus.o_sw_change !== (k == LAT)) begin
        n_mis++;
        $display("FAIL post_reset_sw_change k=%0d got=%b exp=%b", k, bus.o_sw_change, (k == LAT));
      end
      n_cmp++;
      if (bus.o_btn_level !== ((k >= LAT) ? 5'h1F : 5'h00)) begin
        n_mis++;
        $display("FAIL post_reset_btn_level k=%0d got=%h", k, bus.o_btn_level);
      end
    end
    settle('0, '0);
  endtask

  task automatic test_clean_press;
    bus.i_push_btn = 5'b00100;
    for (int k = 1; k <= LAT + 4; k++) begin
      step(1);
      n_cmp++;
      if (bus.o_btn_press !== ((k == LAT) ? 5'b00100 : 5'b00000)) begin
        n_mis++;
        $display("FAIL press_pulse k=%0d got=%b", k, bus.o_btn_press);
      end
      n_cmp++;
      if (bus.o_btn_level !== ((k >= LAT) ? 5'b00100 : 5'b00000)) begin
        n_mis++;
        $display("FAIL press_level k=%0d got=%b", k, bus.o_btn_level);
      end
    end
    bus.i_push_btn = 5'b00000;
    for (int k = 1; k <= LAT + 4; k++) begin
      step(1);
      n_cmp++;
      if (bus.o_btn_release !== ((k == LAT) ? 5'b00100 : 5'b00000)) begin
        n_mis++;
        $display("FAIL release_pulse k=%0d got=%b", k, bus.o_btn_release);
      end
      n_cmp++;
      if (bus.o_btn_level !== ((k >= LAT) ? 5'b00000 : 5'b00100)) begin
        n_mis++;
        $display("FAIL release_level k=%0d got=%b", k, bus.o_btn_level);
      end
    end
  endtask

  task automatic test_bounce;
    for (int seg = 0; seg < 12; seg++) begin
      bus.i_push_btn[0] = (seg % 2 == 0);
      for (int c = 0; c < 5; c++) begin
        step(1);
        n_cmp++;
        if (bus.o_btn_press !== 5'b0 || bus.o_btn_level !== 5'b0) begin
          n_mis++;
          $display("FAIL bounce_quiet seg=%0d got prs=%b lvl=%b", seg, bus.o_btn_press, bus.o_btn_level);
        end
      end
    end
    bus.i_push_btn[0] = 1'b1;
    for (int k = 1; k <= LAT + 4; k++) begin
      step(1);
      n_cmp++;
      if (bus.o_btn_press !== ((k == LAT) ? 5'b00001 : 5'b00000)) begin
        n_mis++;
        $display("FAIL bounce_press k=%0d got=%b", k, bus.o_btn_press);
      end
    end
    settle('0, '0);
  endtask

  task automatic test_glitch;
    bus.i_DIP_sw[3] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 16) bus.i_DIP_sw[3] = 1'b0;
      step(1);
      n_cmp++;
      if (bus.o_sw_level !== 8'h00 || bus.o_sw_change !== 1'b0) begin
        n_mis++;
        $display("FAIL glitch15 k=%0d got sw=%h chg=%b", k, bus.o_sw_level, bus.o_sw_change);
      end
    end
    bus.i_DIP_sw[3] = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      if (k == 17) bus.i_DIP_sw[3] = 1'b0;
      step(1);
      n_cmp++;
      if (bus.o_sw_level !== ((k >= LAT) ? 8'h08 : 8'h00) || bus.o_sw_change !== (k == LAT)) begin
        n_mis++;
        $display("FAIL glitch16 k=%0d got sw=%h chg=%b", k, bus.o_sw_level, bus.o_sw_change);
      end
    end
    settle('0, '0);
  endtask

  task automatic test_simultaneous;
    bus.i_DIP_sw = 8'hA5;
    for (int k = 1; k <= LAT + 4; k++) begin
      step(1);
      n_cmp++;
      if (bus.o_sw_level !== ((k >= LAT) ? 8'hA5 : 8'h00)) begin
        n_mis++;
        $display("FAIL simul_level k=%0d got=%h", k, bus.o_sw_level);
      end
      n_cmp++;
      if (bus.o_sw_change !== (k == LAT)) begin
        n_mis++;
        $display("FAIL simul_change k=%0d got=%b", k, bus.o_sw_change);
      end
    end
    settle('0, '0);
  endtask

  task automatic test_reset_mid_count;
    bus.i_push_btn = 5'b00010;
    step(12);                          // counter has just reached 10
    rst_n = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      n_cmp++;
      if (bus.o_btn_press !== 5'b0 || bus.o_btn_level !== 5'b0) begin
        n_mis++;
        $display("FAIL midreset_hold k=%0d got prs=%b lvl=%b", k, bus.o_btn_press, bus.o_btn_level);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= LAT + LP + 8; k++) begin
      step(1);
      n_cmp++;
      if (bus.o_btn_press !== ((k == LAT) ? 5'b00010 : 5'b00000)) begin
        n_mis++;
        $display("FAIL midreset_press k=%0d got=%b", k, bus.o_btn_press);
      end
`ifdef LONGPRESS_EN
      n_cmp++;
      if (bus.o_btn_long !== ((k == LAT + LP) ? 5'b00010 : 5'b00000)) begin
        n_mis++;
        $display("FAIL long_pulse k=%0d got=%b", k, bus.o_btn_long);
      end
`endif
    end
    settle('0, '0);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
